// File: rtl/spi_frame_tx_if.sv
// Word handshake and SPI pin bundle for spi_frame_tx.
// The master side supplies words and the slave side drives the serial pins.
interface spi_frame_tx_if #(
  parameter int FRAME_BITS = 48
);
  logic [FRAME_BITS-1:0] frame;
  logic                  in_valid;
  logic                  in_ready;
  logic                  sck;
  logic                  sdo;
  logic                  cs_n;
  logic                  busy;
  logic                  done;

  modport master (
    output frame, in_valid,
    input  in_ready, sck, sdo, cs_n, busy, done
  );

  modport slave (
    input  frame, in_valid,
    output in_ready, sck, sdo, cs_n, busy, done
  );
endinterface

// File: rtl/spi_frame_tx.sv
// Mode-0 SPI transmitter: one latched word per cs_n frame, MSB first.
// sck, sdo and cs_n come straight from flops.
module spi_frame_tx #(
  parameter int FRAME_BITS = 48,
  parameter int DIV_HALF   = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  spi_frame_tx_if.slave bus
);
  localparam int PW = $clog2(DIV_HALF + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic                  ph_end;

  assign ph_end = (ph_q == PH_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end

  // bit_q counts rising sck edges issued so far in this frame
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SETUP;
          sh_d    = bus.frame;
          sdo_d   = bus.frame[FRAME_BITS-1];
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (ph_end) begin
          state_d = HIGH;
          ph_d    = '0;
          sck_d   = 1'b1;
          bit_d   = bit_q + 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      HIGH: begin
        if (ph_end) begin
          state_d = LOW;
          ph_d    = '0;
          sck_d   = 1'b0;
          if (bit_q != BIT_LAST) begin
            sh_d  = sh_q << 1;
            sdo_d = sh_d[FRAME_BITS-1];
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      LOW: begin
        if (ph_end) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sdo_d   = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            state_d = HIGH;
            sck_d   = 1'b1;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.sck      = sck_q;
  assign bus.sdo      = sdo_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.done     = done_q;
endmodule
